// File: rtl/spi_master_if.sv
// Control- and bus-side signals of the mode-0 SPI master.
// The master modport is the engine; the slave modport is whatever drives it.
interface spi_master_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] toXmit;
   logic              strobe;
   logic [1:0]        ss_sel;
   logic [DATA_W-1:0] Rcvd;
   logic              Ready;
   logic              mosi;
   logic              sck;
   logic [1:0]        ss;
   logic              miso;

   modport master (
      input  toXmit, strobe, ss_sel, miso,
      output Rcvd, Ready, mosi, sck, ss
   );

   modport slave (
      output toXmit, strobe, ss_sel, miso,
      input  Rcvd, Ready, mosi, sck, ss
   );
endinterface

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master: one full-duplex DATA_W-bit transfer per
// accepted strobe, MSB first, with SETUP and HOLD guard intervals around SHIFT.
module spi_master #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic          clk,
   input  logic          n_rst,
   spi_master_if.master  bus
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] tx_q, rx_q, rcvd_q;
   logic              sck_q, mosi_q, ready_q;
   logic [1:0]        ss_q;
   logic              tick, accept, rise, fall, finish;

   assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      rise    = 1'b0;
      fall    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE:  if (bus.strobe) begin accept = 1'b1; state_d = SETUP; end
         SETUP: if (tick) begin rise = 1'b1; state_d = SHIFT; end
         SHIFT: if (tick) begin
            if (sck_q)                              fall = 1'b1;
            // Final low half-period has elapsed once all bits were clocked
            else if (bit_cnt_q == BIT_W'(DATA_W))   state_d = HOLD;
            else                                    rise = 1'b1;
         end
         HOLD:  if (tick) begin finish = 1'b1; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                cnt_q <= '0;
      else if (state_q == IDLE)  cnt_q <= '0;
      else if (tick)             cnt_q <= '0;
      else                       cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tx_q      <= '0;
         rx_q      <= '0;
         rcvd_q    <= '0;
         bit_cnt_q <= '0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         ready_q   <= 1'b0;
         ss_q      <= 2'b11;
      end else begin
         if (accept) begin
            tx_q      <= bus.toXmit;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= bus.toXmit[DATA_W-1];
            ready_q   <= 1'b0;
            case (bus.ss_sel)
               2'd0:    ss_q <= 2'b10;
               2'd1:    ss_q <= 2'b01;
               default: ss_q <= 2'b11;
            endcase
         end
         if (rise) begin
            sck_q     <= 1'b1;
            rx_q      <= {rx_q[DATA_W-2:0], bus.miso};
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end
         if (fall) begin
            sck_q <= 1'b0;
            if (bit_cnt_q != BIT_W'(DATA_W)) begin
               tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
               mosi_q <= tx_q[DATA_W-2];
            end
         end
         if (finish) begin
            ss_q    <= 2'b11;
            rcvd_q  <= rx_q;
            ready_q <= 1'b1;
            mosi_q  <= 1'b0;
         end
      end
   end

   assign bus.sck   = sck_q;
   assign bus.mosi  = mosi_q;
   assign bus.ss    = ss_q;
   assign bus.Rcvd  = rcvd_q;
   assign bus.Ready = ready_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance with a shifting slave
// model and a CLK_DIV=1 instance with miso looped back from mosi.
module tb_spi_master;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   spi_master_if #(.DATA_W(8)) b4 ();
   spi_master_if #(.DATA_W(8)) b1 ();

   spi_master #(.DATA_W(8), .CLK_DIV(4)) dut4 (.clk(clk), .n_rst(n_rst), .bus(b4.master));
   spi_master #(.DATA_W(8), .CLK_DIV(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(b1.master));

   // Slave: reloads while deselected, shifts its byte out on each sck fall
   logic [7:0] slv_byte = 8'h00;
   logic [7:0] slv_sr   = 8'h00;
   logic       slv_sck_q = 1'b0;
   always @(negedge clk) begin
      slv_sck_q <= b4.sck;
      if (b4.ss == 2'b11)            slv_sr <= slv_byte;
      else if (slv_sck_q && !b4.sck) slv_sr <= {slv_sr[6:0], 1'b0};
   end
   assign b4.miso = slv_sr[7];
   assign b1.miso = b1.mosi;

   int         rises, hi_len, hi_bad, ss_mis, mosi0_cnt, rdy_cnt, rdy_rises, ss11_cnt;
   logic [7:0] cap, first_rcvd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observe the CLK_DIV=4 instance for samples 0..n (one per falling clk edge)
   task automatic mon4(input int n, input logic [1:0] exp_ss, input int pulse_at);
      logic prev_sck, prev_rdy;
      rises = 0; hi_len = 0; hi_bad = 0; ss_mis = 0; mosi0_cnt = 0;
      rdy_cnt = 0; rdy_rises = 0; ss11_cnt = 0; cap = 8'h00; first_rcvd = 8'hxx;
      prev_sck = 1'b0; prev_rdy = 1'b0;
      for (int k = 0; k <= n; k++) begin
         if (k > 0) @(negedge clk);
         if (k == pulse_at) begin b4.strobe = 1'b1; b4.toXmit = 8'h11; end
         if (pulse_at >= 0 && k == pulse_at + 1) b4.strobe = 1'b0;
         if (b4.sck && !prev_sck) begin
            rises++; cap = {cap[6:0], b4.mosi}; hi_len = 1;
         end else if (b4.sck) hi_len++;
         if (!b4.sck && prev_sck && hi_len != 4) hi_bad++;
         if (!b4.Ready && b4.ss != exp_ss) ss_mis++;
         if (!b4.Ready && !b4.mosi) mosi0_cnt++;
         if (b4.Ready) rdy_cnt++;
         if (b4.Ready && !prev_rdy) begin
            rdy_rises++;
            if (rdy_rises == 1) first_rcvd = b4.Rcvd;
         end
         if (b4.ss == 2'b11) ss11_cnt++;
         prev_sck = b4.sck;
         prev_rdy = b4.Ready;
      end
   endtask

   task automatic start4(input logic [7:0] data, input logic [1:0] sel, input logic [7:0] sbyte);
      slv_byte = sbyte;
      b4.toXmit = data;
      b4.ss_sel = sel;
      @(negedge clk);
      b4.strobe = 1'b1;
      @(negedge clk);
      b4.strobe = 1'b0;
   endtask

   initial begin
      int   tog, ss1_mis, waited;
      logic rdy17, prev1;
      b4.toXmit = 8'h00; b4.strobe = 1'b0; b4.ss_sel = 2'd0;
      b1.toXmit = 8'h00; b1.strobe = 1'b0; b1.ss_sel = 2'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sck", b4.sck, 1'b0);
      chk("rst_ss", b4.ss, 2'b11);
      chk("rst_mosi", b4.mosi, 1'b0);
      chk("rst_ready", b4.Ready, 1'b0);
      chk("rst_rcvd", b4.Rcvd, 8'h00);
      n_rst = 1'b1;
      @(negedge clk);

      // 0xA5 to slave 0, slave answers 0x3C
      start4(8'hA5, 2'd0, 8'h3C);
      mon4(72, 2'b10, -1);
      chk("a5_rises", rises, 8);
      chk("a5_mosi_bits", cap, 8'hA5);
      chk("a5_high_len", hi_bad, 0);
      chk("a5_ss_during", ss_mis, 0);
      chk("a5_ready_once", rdy_cnt, 1);
      chk("a5_ready", b4.Ready, 1'b1);
      chk("a5_rcvd", b4.Rcvd, 8'h3C);
      chk("a5_ss_end", b4.ss, 2'b11);
      chk("a5_mosi_end", b4.mosi, 1'b0);

      // 0xFF to slave 1, miso held low
      start4(8'hFF, 2'd1, 8'h00);
      mon4(72, 2'b01, -1);
      chk("ff_ss_during", ss_mis, 0);
      chk("ff_mosi_const", mosi0_cnt, 0);
      chk("ff_mosi_bits", cap, 8'hFF);
      chk("ff_rcvd", b4.Rcvd, 8'h00);
      chk("ff_ready", b4.Ready, 1'b1);
      b4.toXmit = 8'h77;
      repeat (5) @(negedge clk);
      chk("ff_ready_level", b4.Ready, 1'b1);
      chk("ff_rcvd_stable", b4.Rcvd, 8'h00);

      // Strobe pulse during SHIFT is ignored
      start4(8'h96, 2'd0, 8'hE7);
      mon4(90, 2'b10, 30);
      chk("ign_mosi_bits", cap, 8'h96);
      chk("ign_rises", rises, 8);
      chk("ign_ready_rises", rdy_rises, 1);
      chk("ign_rcvd", b4.Rcvd, 8'hE7);
      chk("ign_ready_hold", rdy_cnt, 19);

      // Strobe held high: back-to-back transfers
      slv_byte = 8'h3C;
      b4.toXmit = 8'h5A;
      b4.ss_sel = 2'd0;
      @(negedge clk);
      b4.strobe = 1'b1;
      @(negedge clk);
      mon4(230, 2'b10, -1);
      chk("b2b_ready_rises", rdy_rises, 3);
      chk("b2b_ready_cycles", rdy_cnt, 3);
      chk("b2b_ss_idle_cycles", ss11_cnt, 3);
      chk("b2b_first_rcvd", first_rcvd, 8'h3C);
      b4.strobe = 1'b0;
      waited = 0;
      while (!b4.Ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("b2b_last_ready", b4.Ready, 1'b1);
      chk("b2b_last_rcvd", b4.Rcvd, 8'h3C);

      // Reset during the fourth sck pulse
      start4(8'hA5, 2'd0, 8'h3C);
      mon4(29, 2'b10, -1);
      chk("abort_rises", rises, 4);
      chk("abort_sck_pre", b4.sck, 1'b1);
      n_rst = 1'b0;
      #1;
      chk("abort_sck", b4.sck, 1'b0);
      chk("abort_ss", b4.ss, 2'b11);
      chk("abort_ready", b4.Ready, 1'b0);
      chk("abort_rcvd", b4.Rcvd, 8'h00);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      start4(8'hC3, 2'd0, 8'h3C);
      mon4(72, 2'b10, -1);
      chk("c3_mosi_bits", cap, 8'hC3);
      chk("c3_ready", b4.Ready, 1'b1);
      chk("c3_rcvd", b4.Rcvd, 8'h3C);

      // CLK_DIV=1, no slave selected, loopback
      b1.toXmit = 8'h81;
      b1.ss_sel = 2'd2;
      @(negedge clk);
      b1.strobe = 1'b1;
      @(negedge clk);
      b1.strobe = 1'b0;
      tog = 0; ss1_mis = 0; rdy17 = 1'b1; prev1 = 1'b0;
      for (int k = 0; k <= 18; k++) begin
         if (k > 0) @(negedge clk);
         if (b1.sck != prev1) tog++;
         if (b1.ss != 2'b11) ss1_mis++;
         if (k == 17) rdy17 = b1.Ready;
         prev1 = b1.sck;
      end
      chk("div1_toggles", tog, 16);
      chk("div1_ss_idle", ss1_mis, 0);
      chk("div1_ready_early", rdy17, 1'b0);
      chk("div1_ready", b1.Ready, 1'b1);
      chk("div1_rcvd", b1.Rcvd, 8'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
